// File: rtl/coax_tx_feeder_if.sv
// Coax transmit feeder bus: write port, FIFO status and
// transmitter load handshake grouped for the feeder block.
interface coax_tx_feeder_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [9:0]    wr_data;
  logic          wr_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clear_overflow;
  logic [9:0]    tx_data;
  logic          tx_load;
  logic          tx_full;
  logic          tx_active;
  logic          busy;

  modport master (
    output wr_data, wr_en, clear_overflow,
    output tx_full, tx_active,
    input  fifo_full, fifo_empty, fifo_count,
    input  overflow, tx_data, tx_load, busy
  );

  modport slave (
    input  wr_data, wr_en, clear_overflow,
    input  tx_full, tx_active,
    output fifo_full, fifo_empty, fifo_count,
    output overflow, tx_data, tx_load, busy
  );
endinterface

// File: rtl/coax_tx_feeder.sv
// Coax transmit feeder: circular word FIFO feeding a
// 4-cycle load sequencer for the downstream transmitter.
module coax_tx_feeder #(
  parameter int DEPTH = 16
) (
  input logic              clk,
  input logic              reset,
  coax_tx_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    SETTLE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nx;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_load;
  logic [9:0]    r_data;
  logic          w_wr;
  logic          w_pop;

  // A full FIFO drops the write even if a pop frees a slot
  assign w_wr = bus.wr_en && !r_full;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_empty && !bus.tx_full) begin
          w_pop  = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD:    w_next = STROBE;
      STROBE:  w_next = SETTLE;
      SETTLE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_count_nx = r_count;
    if (w_wr && !w_pop) begin
      w_count_nx = r_count + CW'(1);
    end else if (!w_wr && w_pop) begin
      w_count_nx = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_load  <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_data <= r_mem[r_rptr];
      end
      r_count <= w_count_nx;
      r_full  <= (w_count_nx == CW'(DEPTH));
      r_empty <= (w_count_nx == '0);
      r_load  <= w_pop;
      if (bus.wr_en && r_full) begin
        r_ovf <= 1'b1;
      end else if (bus.clear_overflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.fifo_count = r_count;
  assign bus.fifo_full  = r_full;
  assign bus.fifo_empty = r_empty;
  assign bus.overflow   = r_ovf;
  assign bus.tx_load    = r_load;
  assign bus.tx_data    = r_data;
  assign bus.busy       = !r_empty || (r_state != IDLE)
                          || bus.tx_active;
endmodule

// File: tb/tb_coax_tx_feeder.sv
// Bench for coax_tx_feeder: directed scenarios plus random
// traffic against a queue-based reference of the feeder.
module tb_coax_tx_feeder;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk;
  logic reset;
  coax_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  coax_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise = -1;

  logic [9:0] q[$];
  logic [9:0] cap[$];
  int         cool = 0;
  logic [9:0] e_data = '0;
  logic       e_load = 1'b0;
  logic       e_ovf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the reference, compare.
  task automatic step(input logic rst, input logic we,
                      input logic [9:0] wd, input logic clr,
                      input logic tf, input logic ta);
    int   sz;
    logic pop;
    logic prev_load;
    reset              = rst;
    bus.wr_en          = we;
    bus.wr_data        = wd;
    bus.clear_overflow = clr;
    bus.tx_full        = tf;
    bus.tx_active      = ta;
    prev_load = bus.tx_load;
    @(posedge clk);
    cyc++;
    sz  = q.size();
    pop = (cool == 0) && (sz > 0) && !tf;
    if (rst) begin
      q.delete();
      cool   = 0;
      e_data = '0;
      e_load = 1'b0;
      e_ovf  = 1'b0;
    end else begin
      if (pop) begin
        e_data = q.pop_front();
        e_load = 1'b1;
        cool   = 3;
      end else begin
        e_load = 1'b0;
        if (cool > 0) cool--;
      end
      if (we && sz < DEPTH) q.push_back(wd);
      if (we && sz == DEPTH) e_ovf = 1'b1;
      else if (clr) e_ovf = 1'b0;
    end
    #1;
    chk("count", 32'(bus.fifo_count), 32'(q.size()));
    chk("full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
    chk("empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
    chk("overflow", 32'(bus.overflow), 32'(e_ovf));
    chk("tx_load", 32'(bus.tx_load), 32'(e_load));
    chk("tx_data", 32'(bus.tx_data), 32'(e_data));
    chk("busy", 32'(bus.busy),
        32'((q.size() > 0) || (cool > 0) || ta));
    if (rst) begin
      last_rise = -1;
    end else if (bus.tx_load && !prev_load) begin
      chk("load_while_full", 32'(tf), 32'(0));
      if (last_rise >= 0)
        chk("spacing", 32'((cyc - last_rise) >= 4), 32'(1));
      last_rise = cyc;
    end
    if (!rst && prev_load && !bus.tx_load)
      cap.push_back(bus.tx_data);
  endtask

  initial begin
    int ncap;
    int hold;
    logic [9:0] wv [3];
    logic [9:0] cv;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.clear_overflow = 1'b0;
    bus.tx_full = 1'b0;
    bus.tx_active = 1'b0;

    // Reset overrides write and clear; busy follows tx_active
    step(1, 1, 10'h3FF, 1, 0, 1);
    step(1, 1, 10'h155, 1, 0, 0);

    // Single write, pop one edge later
    step(0, 1, 10'h2A5, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // Fill past DEPTH with transmitter blocked
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i <= DEPTH; i++)
      step(0, 1, 10'(i + 10'h100), 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // Drop and clear together: drop wins
    step(0, 1, 10'h3AA, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4 * DEPTH + 4; i++)
      step(0, 0, 0, 0, 0, 0);

    // Ordered captures with back-pressure after the second
    step(1, 0, 0, 0, 0, 0);
    cap.delete();
    wv[0] = 10'h001;
    wv[1] = 10'h155;
    wv[2] = 10'h3FF;
    ncap = 0;
    hold = 0;
    for (int i = 0; i < 40; i++) begin
      logic tf;
      tf = (ncap >= 2) && (hold < 8);
      if (tf) hold++;
      if (i < 3) step(0, 1, wv[i], 0, tf, 1);
      else step(0, 0, 0, 0, tf, 0);
      ncap = cap.size();
    end
    chk("cap_count", 32'(cap.size()), 32'(3));
    for (int i = 0; i < 3; i++) begin
      cv = (i < cap.size()) ? cap[i] : 10'h000;
      chk("cap_order", 32'(cv), 32'(wv[i]));
    end

    // Write and pop on the same edge at count 1
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 10'h0F0, 0, 1, 0);
    step(0, 1, 10'h10F, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // Reset landing in STROBE, then a fresh write
    step(0, 1, 10'h2CC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 10'h2A5, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) < 2,
           $urandom_range(99) < 55,
           10'($urandom),
           $urandom_range(99) < 5,
           $urandom_range(99) < 35,
           $urandom_range(99) < 30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
